// File: rtl/fir_channel_sequencer_if.sv
// fir_channel_sequencer_if: start/stop, ADC handshake, LED, filter-step and status signals of the sequencer
interface fir_channel_sequencer_if;
  logic start;
  logic stop;
  logic [7:0] adc_data;
  logic adc_ready;
  logic adc_conv;
  logic led_red;
  logic led_ir;
  logic [7:0] fir_sample;
  logic fir_red_en;
  logic fir_ir_en;
  logic red_valid;
  logic ir_valid;
  logic busy;
  logic overrun;
  logic adc_err;
  modport master (
    input start, stop, adc_data, adc_ready,
    output adc_conv, led_red, led_ir, fir_sample, fir_red_en, fir_ir_en,
    output red_valid, ir_valid, busy, overrun, adc_err
  );
  modport slave (
    output start, stop, adc_data, adc_ready,
    input adc_conv, led_red, led_ir, fir_sample, fir_red_en, fir_ir_en,
    input red_valid, ir_valid, busy, overrun, adc_err
  );
endinterface

// File: rtl/fir_channel_sequencer.sv
// fir_channel_sequencer: red/IR LED, ADC and FIR-step sequencer; ADC timeout enabled by FIR_SEQ_TIMEOUT_EN
module fir_channel_sequencer #(
  parameter int DIV = 1000,
  parameter int SETTLE = 4,
  parameter int WARMUP = 24,
  parameter int ADC_TIMEOUT = 64
) (
  input logic CLK_Filter,
  input logic rst_n,
  fir_channel_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, SETTLE_R, CONV_R, WAIT_R, SETTLE_I, CONV_I, WAIT_I, WAIT_TICK} state_t;
  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
  localparam logic [7:0] SET_M1 = 8'(SETTLE - 1);
  localparam int WW = $clog2(WARMUP + 1);
  localparam logic [WW-1:0] WU = WW'(WARMUP);
  localparam logic [WW-1:0] WU_M1 = WW'(WARMUP - 1);
  state_t state, state_n;
  logic [15:0] tcnt;
  logic [7:0] scnt;
  logic [WW-1:0] wr, wi;
  logic gap, stop_p, stop_any, tick, in_wait, in_settle, settled, got, tmo, done;
  assign in_wait = state == WAIT_R || state == WAIT_I;
  assign in_settle = state == SETTLE_R || state == SETTLE_I;
  assign got = in_wait && bus.adc_ready;
  assign done = got || tmo;
  assign tick = state != IDLE && tcnt == 16'd0;
  assign stop_any = stop_p || bus.stop;
  // gap is the dark cycle between red LED off and IR LED on; it is not counted as settling
  assign settled = in_settle && !gap && scnt == SET_M1;
  always_ff @(posedge CLK_Filter)
    if (rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (bus.start && !bus.stop) state_n = SETTLE_R;
      SETTLE_R:  if (settled) state_n = CONV_R;
      CONV_R:    state_n = WAIT_R;
      WAIT_R:    if (done) state_n = SETTLE_I;
      SETTLE_I:  if (settled) state_n = CONV_I;
      CONV_I:    state_n = WAIT_I;
      WAIT_I:    if (done) state_n = stop_any ? IDLE : WAIT_TICK;
      WAIT_TICK: if (stop_any) state_n = IDLE;
                 else if (tick) state_n = SETTLE_R;
      default:   state_n = IDLE;
    endcase
  end
  always_comb begin
    bus.busy = state != IDLE;
    bus.adc_conv = state == CONV_R || state == CONV_I;
    bus.led_red = state == SETTLE_R || state == CONV_R || state == WAIT_R;
    bus.led_ir = (state == SETTLE_I && !gap) || state == CONV_I || state == WAIT_I;
  end
  always_ff @(posedge CLK_Filter)
    if (rst_n) begin
      tcnt <= 16'd0;
      scnt <= 8'd0;
      gap <= 1'b0;
      stop_p <= 1'b0;
      wr <= '0;
      wi <= '0;
      bus.fir_sample <= 8'd0;
      bus.fir_red_en <= 1'b0;
      bus.fir_ir_en <= 1'b0;
      bus.red_valid <= 1'b0;
      bus.ir_valid <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      tcnt <= state == IDLE ? (state_n == SETTLE_R ? DIV_M1 : 16'd0) : (tcnt == 16'd0 ? DIV_M1 : tcnt - 16'd1);
      scnt <= in_settle && !gap && !settled ? scnt + 8'd1 : 8'd0;
      gap <= state == WAIT_R && done;
      stop_p <= state_n == IDLE ? 1'b0 : stop_any;
      if (got) bus.fir_sample <= bus.adc_data;
      bus.fir_red_en <= state == WAIT_R && got;
      bus.fir_ir_en <= state == WAIT_I && got;
      bus.red_valid <= bus.fir_red_en && wr >= WU_M1;
      bus.ir_valid <= bus.fir_ir_en && wi >= WU_M1;
      wr <= bus.fir_red_en && wr != WU ? wr + WW'(1) : wr;
      wi <= bus.fir_ir_en && wi != WU ? wi + WW'(1) : wi;
      if (tick && state != WAIT_TICK) bus.overrun <= 1'b1;
    end
`ifdef FIR_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(ADC_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_M1 = TW'(ADC_TIMEOUT - 1);
  logic [TW-1:0] wcnt;
  assign tmo = in_wait && !bus.adc_ready && wcnt == TO_M1;
  always_ff @(posedge CLK_Filter)
    if (rst_n) begin
      wcnt <= '0;
      bus.adc_err <= 1'b0;
    end else begin
      wcnt <= in_wait && !done ? wcnt + TW'(1) : '0;
      if (tmo) bus.adc_err <= 1'b1;
    end
`else
  logic timeout_unused;
  assign timeout_unused = ADC_TIMEOUT != 0;
  assign tmo = 1'b0;
  assign bus.adc_err = 1'b0;
`endif
endmodule

// File: tb/tb_fir_channel_sequencer.sv
// tb_fir_channel_sequencer: directed scenarios with a bench ADC model and a sample scoreboard
module tb_fir_channel_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  fir_channel_sequencer_if bus();
  fir_channel_sequencer #(.DIV(40), .SETTLE(2), .WARMUP(3), .ADC_TIMEOUT(8)) dut (
    .CLK_Filter(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  int tests = 0, fails = 0, cyc = 0, cd = 0, dly_r = 3, dly_i = 3;
  int nconv = 0, nren = 0, nien = 0, nrv = 0, niv = 0, base;
  bit withhold_r = 1'b0;
  logic [7:0] adc_val = 8'h5A;
  logic [8:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // one clock: bench ADC answers cd cycles after adc_conv; every filter enable is scored
  task automatic step();
    logic [8:0] e;
    @(posedge clk);
    #1;
    cyc++;
    bus.adc_ready = 1'b0;
    if (cd == 1) begin
      bus.adc_ready = 1'b1;
      bus.adc_data = adc_val;
      sb.push_back({bus.led_ir, adc_val});
      adc_val = adc_val + 8'h11;
    end
    if (cd > 0) cd--;
    if (bus.adc_conv) begin
      nconv++;
      cd = bus.led_red ? (withhold_r ? 0 : dly_r) : dly_i;
    end
    if (bus.fir_red_en || bus.fir_ir_en) begin
      chk("sb_pending", 32'(sb.size() != 0), 32'd1);
      e = 9'h1FF;
      if (sb.size() != 0) e = sb.pop_front();
      chk("sb_sample", 32'(bus.fir_sample), 32'(e[7:0]));
      chk("sb_chan", 32'(bus.fir_ir_en), 32'(e[8]));
    end
    if (bus.fir_red_en) nren++;
    if (bus.fir_ir_en) nien++;
    if (bus.red_valid) nrv++;
    if (bus.ir_valid) niv++;
    chk("led_excl", 32'(bus.led_red & bus.led_ir), 32'd0);
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.adc_data = 8'h00;
    bus.adc_ready = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_leds", 32'({bus.led_red, bus.led_ir, bus.adc_conv}), 32'd0);
    chk("rst_sample", 32'(bus.fir_sample), 32'd0);
    chk("rst_flags", 32'({bus.overrun, bus.adc_err, bus.red_valid, bus.ir_valid, bus.fir_red_en, bus.fir_ir_en}), 32'd0);
    rst_n = 1'b0;
    step();
    // nominal pair and warm-up over four ticks
    cyc = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("nom_led_red_1", 32'(bus.led_red), 32'd1);
    chk("nom_busy_1", 32'(bus.busy), 32'd1);
    run_to(2);
    chk("nom_conv_2", 32'(bus.adc_conv), 32'd0);
    run_to(3);
    chk("nom_conv_3", 32'(bus.adc_conv), 32'd1);
    chk("nom_led_red_3", 32'(bus.led_red), 32'd1);
    run_to(7);
    chk("nom_red_en_7", 32'(bus.fir_red_en), 32'd1);
    chk("nom_sample_7", 32'(bus.fir_sample), 32'h5A);
    chk("nom_leds_7", 32'({bus.led_red, bus.led_ir}), 32'd0);
    run_to(8);
    chk("nom_led_ir_8", 32'(bus.led_ir), 32'd1);
    chk("nom_red_valid_8", 32'(bus.red_valid), 32'd0);
    run_to(10);
    chk("nom_conv_ir_10", 32'(bus.adc_conv), 32'd1);
    run_to(12);
    chk("nom_hold_12", 32'(bus.fir_sample), 32'h5A);
    run_to(14);
    chk("nom_ir_en_14", 32'(bus.fir_ir_en), 32'd1);
    chk("nom_ir_sample_14", 32'(bus.fir_sample), 32'h6B);
    run_to(40);
    chk("tick2_led_40", 32'(bus.led_red), 32'd0);
    chk("tick2_busy_40", 32'(bus.busy), 32'd1);
    run_to(41);
    chk("tick2_led_41", 32'(bus.led_red), 32'd1);
    run_to(80);
    chk("warm_p2_red", 32'(nrv), 32'd0);
    chk("warm_p2_ir", 32'(niv), 32'd0);
    run_to(87);
    chk("warm_p3_rv_87", 32'(bus.red_valid), 32'd0);
    run_to(88);
    chk("warm_p3_rv_88", 32'(bus.red_valid), 32'd1);
    run_to(120);
    chk("warm_p3_red", 32'(nrv), 32'd1);
    chk("warm_p3_ir", 32'(niv), 32'd1);
    run_to(160);
    chk("warm_p4_red", 32'(nrv), 32'd2);
    chk("warm_p4_ir", 32'(niv), 32'd2);
    chk("warm_en_count", 32'(nren + nien), 32'd8);
    // stop raised during SETTLE_I of pair 5: IR still finishes
    run_to(168);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    run_to(173);
    chk("stop_busy_173", 32'(bus.busy), 32'd1);
    run_to(174);
    chk("stop_busy_174", 32'(bus.busy), 32'd0);
    chk("stop_leds_174", 32'({bus.led_red, bus.led_ir}), 32'd0);
    chk("stop_ir_en_174", 32'(bus.fir_ir_en), 32'd1);
    run_to(185);
    chk("stop_idle_185", 32'(bus.busy), 32'd0);
    chk("stop_ir_valid", 32'(niv), 32'd3);
    // overrun: red answer delayed past the tick
    dly_r = 45;
    base = nconv;
    cyc = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    run_to(40);
    chk("ovr_before_40", 32'(bus.overrun), 32'd0);
    run_to(41);
    chk("ovr_set_41", 32'(bus.overrun), 32'd1);
    chk("ovr_no_restart_41", 32'(nconv - base), 32'd1);
    run_to(49);
    chk("ovr_red_en_49", 32'(bus.fir_red_en), 32'd1);
    dly_r = 3;
    run_to(80);
    chk("ovr_led_80", 32'(bus.led_red), 32'd0);
    chk("ovr_conv_cnt_80", 32'(nconv - base), 32'd2);
    run_to(81);
    chk("ovr_next_81", 32'(bus.led_red), 32'd1);
    run_to(100);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("ovr_stop_idle", 32'(bus.busy), 32'd0);
    chk("ovr_sticky", 32'(bus.overrun), 32'd1);
    // start with stop in IDLE
    bus.start = 1'b1;
    bus.stop = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    chk("ss_busy", 32'(bus.busy), 32'd0);
    step();
    step();
    chk("ss_still_idle", 32'({bus.busy, bus.led_red}), 32'd0);
`ifdef FIR_SEQ_TIMEOUT_EN
    withhold_r = 1'b1;
    base = nren;
    cyc = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    withhold_r = 1'b0;
    run_to(11);
    chk("tmo_err_11", 32'(bus.adc_err), 32'd0);
    run_to(12);
    chk("tmo_err_12", 32'(bus.adc_err), 32'd1);
    chk("tmo_leds_12", 32'({bus.led_red, bus.led_ir}), 32'd0);
    run_to(13);
    chk("tmo_led_ir_13", 32'(bus.led_ir), 32'd1);
    run_to(19);
    chk("tmo_ir_en_19", 32'(bus.fir_ir_en), 32'd1);
    chk("tmo_no_red_en", 32'(nren - base), 32'd0);
    run_to(25);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("tmo_idle", 32'(bus.busy), 32'd0);
`else
    chk("no_tmo_err", 32'(bus.adc_err), 32'd0);
`endif
    // reset during CONV_R
    cyc = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    run_to(3);
    chk("rc_conv_3", 32'(bus.adc_conv), 32'd1);
    rst_n = 1'b1;
    cd = 0;
    step();
    chk("rc_outs", 32'({bus.busy, bus.led_red, bus.led_ir, bus.adc_conv}), 32'd0);
    chk("rc_flags", 32'({bus.overrun, bus.adc_err, bus.fir_red_en, bus.fir_ir_en, bus.red_valid, bus.ir_valid}), 32'd0);
    chk("rc_sample", 32'(bus.fir_sample), 32'd0);
    rst_n = 1'b0;
    step();
    step();
    chk("rc_idle", 32'(bus.busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
